count_ascii_sender: RTL and testbench
=====================================

# count_ascii_sender

Reports the 14-bit up/down counter value over the UART transmit path, the opposite direction to the existing receive-command path. On a single-cycle trigger it latches `count` and converts it to four decimal digits. It then sends those digits through the `uart` transmitter handshake as ASCII, optionally followed by CR LF. It sits between `UpDownCounter` (source of `count`) and the `start`/`tx_data` inputs of `uart`.

## Interface
- `SEND_CRLF`, default 1: when 1, append 0x0D, 0x0A after the digits (6 bytes per frame); when 0, send 4 bytes.
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `trigger`  in  1  single-cycle send request (button edge or rx command decode).
- `count`  in  14  counter value; sampled only on an accepted trigger.
- `tx_busy`  in  1  from `uart`; high while a byte is shifting out.
- `tx_done`  in  1  from `uart`; one-cycle pulse at end of each byte.
- `tx_start`  out  1  one-cycle request to `uart` to send `tx_data`.
- `tx_data`  out  8  byte to send; stable from the `tx_start` cycle until the matching `tx_done`.
- `busy`  out  1  high while a frame is being converted or sent.

## Operation
- Reset values: `tx_start`=0, `tx_data`=8'h00, `busy`=0, state IDLE, byte index 0, latched value 0.
- States:
  - IDLE: `trigger`=1 → latch `count`, go to CONVERT.
  - CONVERT: 14 shift-add-3 iterations, one per clock → START.
  - START: if `tx_busy`=0, pulse `tx_start` and go to WAIT_DONE; otherwise stay in START.
  - WAIT_DONE: on `tx_done`, if the last byte was sent go to IDLE, otherwise increment the byte index and go to START.
- Saturation: a latched value > 9999 is replaced by 9999 before conversion.
- Byte order: thousands, hundreds, tens, ones digit, each sent as 8'h30 + digit, then CR and LF if `SEND_CRLF`=1. Leading zeros are always sent.
- Triggers arriving when not in IDLE are dropped and are not queued. This includes a trigger in the same cycle as the frame's final `tx_done`.
- `count` changes after the latch do not affect the frame in progress.
- `tx_done` outside WAIT_DONE is ignored.
- Reset asserted mid-frame aborts immediately: outputs return to their reset values and no further `tx_start` is issued.

## Timing
- The trigger is sampled at edge T.
- `busy` rises at edge T (visible cycle T+1).
- CONVERT occupies cycles T+1..T+14. The first `tx_start` is high during cycle T+15 if `tx_busy`=0.
- `tx_start` is high for exactly one clock per byte and is never asserted while `tx_busy`=1.
- `tx_data` is updated in the same edge that raises `tx_start`.
- `tx_done` sampled at edge D → the next byte's `tx_start` is high during cycle D+1, if `tx_busy`=0.
- Final `tx_done` at edge D → `busy`=0 from cycle D+1. A trigger is accepted from edge D+1 onward.
- No combinational path from any input to any output.

## Structure
- Package `uart_report_pkg`:
  - state enum `{IDLE, CONVERT, START, WAIT_DONE}`;
  - `NUM_DIGITS`=4;
  - `ASCII_ZERO`=8'h30, `ASCII_CR`=8'h0D, `ASCII_LF`=8'h0A;
  - `COUNT_MAX`=14'd9999.
- Sub-module `bin2bcd_seq`: iterative double-dabble converter.
  - Ports: `clk`, `reset`, `start`, `bin[13:0]`, `bcd[15:0]`, `done`.
  - Latency 14 clocks.
- The top FSM owns the byte mux and the handshake.

## Test plan
- `count`=1234, trigger, UART model returns `tx_done` 10 clocks after each `tx_start` → bytes 0x31 0x32 0x33 0x34 0x0D 0x0A in order. First `tx_start` at T+15. `busy` falls the cycle after the 6th `tx_done`.
- `count`=7 with `SEND_CRLF`=0 → bytes 0x30 0x30 0x30 0x37. Exactly 4 `tx_start` pulses.
- `count`=12000 → digits 0x39 0x39 0x39 0x39; `count`=0 → 0x30 ×4.
- Hold `tx_busy`=1 for 20 cycles at T+15 → `tx_start` stays 0 until the cycle after `tx_busy` falls, then pulses once with `tx_data`=0x31.
- Second trigger during byte 2, and a trigger coincident with the final `tx_done` → both ignored, only one frame is sent. A trigger at D+1 starts a new frame.
- Assert `reset` for 2 cycles during WAIT_DONE of byte 3 → `tx_start`=0, `tx_data`=0x00, `busy`=0 immediately. No stray byte after release. A new trigger yields a full correct frame.

Source files
------------

// File: rtl/count_ascii_sender_pkg.sv
// Shared types, constants and arithmetic helpers for the count-to-ASCII UART reporter.
package uart_report_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CONVERT   = 2'd1,
    START     = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  localparam int          NUM_DIGITS = 4;
  localparam logic [7:0]  ASCII_ZERO = 8'h30;
  localparam logic [7:0]  ASCII_CR   = 8'h0D;
  localparam logic [7:0]  ASCII_LF   = 8'h0A;
  localparam logic [13:0] COUNT_MAX  = 14'd9999;

  // One double-dabble step: add 3 to every digit >= 5, then shift {bcd, bin} left by one.
  function automatic logic [29:0] dd_step(input logic [15:0] bcd, input logic [13:0] bin);
    logic [15:0] adj;
    adj = bcd;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (adj[4*d +: 4] >= 4'd5) begin
        adj[4*d +: 4] = adj[4*d +: 4] + 4'd3;
      end
    end
    return {adj[14:0], bin, 1'b0};
  endfunction

  function automatic logic [13:0] saturate(input logic [13:0] value);
    return (value > COUNT_MAX) ? COUNT_MAX : value;
  endfunction

  function automatic logic [7:0] frame_byte(input logic [2:0] idx, input logic [15:0] bcd);
    logic [7:0] result;
    case (idx)
      3'd0:    result = ASCII_ZERO + {4'h0, bcd[15:12]};
      3'd1:    result = ASCII_ZERO + {4'h0, bcd[11:8]};
      3'd2:    result = ASCII_ZERO + {4'h0, bcd[7:4]};
      3'd3:    result = ASCII_ZERO + {4'h0, bcd[3:0]};
      3'd4:    result = ASCII_CR;
      3'd5:    result = ASCII_LF;
      default: result = ASCII_ZERO;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble converter: 14-bit binary to four BCD digits, one step per clock.
// The first step is applied on the start edge so the result settles 14 edges after start.
module bin2bcd_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [13:0] bin,
  output logic [15:0] bcd,
  output logic        done
);
  import uart_report_pkg::*;

  logic [15:0] r_bcd;
  logic [13:0] r_bin;
  logic [3:0]  r_cnt;
  logic        r_active;
  logic        r_done;
  logic [29:0] w_first;
  logic [29:0] w_next;

  assign w_first = dd_step(16'h0000, bin);
  assign w_next  = dd_step(r_bcd, r_bin);
  assign bcd     = r_bcd;
  assign done    = r_done;

  // Shift/add-3 iteration engine with a one-cycle done pulse after the last step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bcd    <= 16'h0000;
      r_bin    <= 14'd0;
      r_cnt    <= 4'd0;
      r_active <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (start) begin
        r_bcd    <= w_first[29:14];
        r_bin    <= w_first[13:0];
        r_cnt    <= 4'd13;
        r_active <= 1'b1;
      end else if (r_active) begin
        r_bcd <= w_next[29:14];
        r_bin <= w_next[13:0];
        r_cnt <= r_cnt - 4'd1;
        if (r_cnt == 4'd1) begin
          r_active <= 1'b0;
          r_done   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/count_ascii_sender.sv
// Latches the counter on a trigger, converts it to decimal and streams the ASCII digits
// (optionally followed by CR LF) through the uart start/done handshake.
module count_ascii_sender #(
  parameter bit SEND_CRLF = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        trigger,
  input  logic [13:0] count,
  input  logic        tx_busy,
  input  logic        tx_done,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  output logic        busy
);
  import uart_report_pkg::*;

  localparam logic [2:0] LAST_IDX = SEND_CRLF ? 3'd5 : 3'd3;

  state_t      r_state;
  logic [2:0]  r_idx;
  logic        r_tx_start;
  logic [7:0]  r_tx_data;
  logic        r_busy;

  logic        w_accept;
  logic [13:0] w_sat;
  logic [15:0] w_bcd;
  logic        w_conv_done;
  logic [2:0]  w_next_idx;

  assign w_accept   = (r_state == IDLE) && trigger;
  assign w_sat      = saturate(count);
  assign w_next_idx = r_idx + 3'd1;

  assign tx_start = r_tx_start;
  assign tx_data  = r_tx_data;
  assign busy     = r_busy;

  bin2bcd_seq u_bin2bcd (
    .clk   (clk),
    .reset (reset),
    .start (w_accept),
    .bin   (w_sat),
    .bcd   (w_bcd),
    .done  (w_conv_done)
  );

  // Frame sequencer; a pending byte is issued on the same edge that makes it eligible.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_idx      <= 3'd0;
      r_tx_start <= 1'b0;
      r_tx_data  <= 8'h00;
      r_busy     <= 1'b0;
    end else begin
      r_tx_start <= 1'b0;
      case (r_state)
        IDLE: begin
          if (trigger) begin
            r_state <= CONVERT;
            r_busy  <= 1'b1;
            r_idx   <= 3'd0;
          end
        end
        CONVERT: begin
          if (w_conv_done) begin
            if (!tx_busy) begin
              r_tx_start <= 1'b1;
              r_tx_data  <= frame_byte(3'd0, w_bcd);
              r_state    <= WAIT_DONE;
            end else begin
              r_state <= START;
            end
          end
        end
        START: begin
          if (!tx_busy) begin
            r_tx_start <= 1'b1;
            r_tx_data  <= frame_byte(r_idx, w_bcd);
            r_state    <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (tx_done) begin
            if (r_idx == LAST_IDX) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
              r_idx   <= 3'd0;
            end else begin
              r_idx <= w_next_idx;
              if (!tx_busy) begin
                r_tx_start <= 1'b1;
                r_tx_data  <= frame_byte(w_next_idx, w_bcd);
                r_state    <= WAIT_DONE;
              end else begin
                r_state <= START;
              end
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_idx   <= 3'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_count_ascii_sender.sv
// Scoreboard bench: directed frames push expected bytes; a negedge monitor pops on every tx_start.
module tb_count_ascii_sender;

  logic        clk;
  logic        reset;
  logic [13:0] count;
  logic        trig [2];
  logic        tb_busy [2];
  logic        tb_done [2];
  logic        ts [2];
  logic [7:0]  td [2];
  logic        bz [2];
  logic        mbusy [2];
  int          mcnt [2];
  int          n_start [2];
  int          n_done [2];
  logic        hold;
  int          cyc;
  int          exp_first;
  bit          chk_first;
  int          n_checks;
  int          n_fail;
  logic [7:0]  mon_e;
  logic [7:0]  q0 [$];
  logic [7:0]  q1 [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign tb_busy[0] = mbusy[0];
  assign tb_busy[1] = mbusy[1] | hold;

  count_ascii_sender #(.SEND_CRLF(1'b0)) dut0 (
    .clk(clk), .reset(reset), .trigger(trig[0]), .count(count),
    .tx_busy(tb_busy[0]), .tx_done(tb_done[0]),
    .tx_start(ts[0]), .tx_data(td[0]), .busy(bz[0])
  );

  count_ascii_sender dut1 (
    .clk(clk), .reset(reset), .trigger(trig[1]), .count(count),
    .tx_busy(tb_busy[1]), .tx_done(tb_done[1]),
    .tx_start(ts[1]), .tx_data(td[1]), .busy(bz[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  function automatic int qsize(input int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out waiting, expected event within bound", name);
  endtask

  task automatic pulse(input int k);
    trig[k] = 1'b1;
    tick();
    trig[k] = 1'b0;
  endtask

  task automatic wait_idle(input int k);
    int g;
    g = 0;
    while ((bz[k] || qsize(k) != 0) && g < 3000) begin
      tick();
      g++;
    end
    if (g >= 3000) timeout("wait_idle");
  endtask

  // Monitor (checks first) followed by the uart model: done pulse 10 cycles after each start.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (ts[k]) begin
        n_start[k] = n_start[k] + 1;
        check("start_while_busy", {31'd0, tb_busy[k]}, 32'd0);
        if (k == 1 && chk_first) begin
          check("first_start_cycle", cyc, exp_first);
          chk_first = 1'b0;
        end
        if (qsize(k) == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_byte dut%0d: got %02h, no byte expected", k, td[k]);
        end else begin
          mon_e = (k == 0) ? q0.pop_front() : q1.pop_front();
          check("tx_data_byte", {24'd0, td[k]}, {24'd0, mon_e});
        end
      end
      if (reset) begin
        mbusy[k]   = 1'b0;
        mcnt[k]    = 0;
        tb_done[k] = 1'b0;
      end else begin
        tb_done[k] = 1'b0;
        if (ts[k]) begin
          mbusy[k] = 1'b1;
          mcnt[k]  = 10;
        end else if (mcnt[k] > 0) begin
          mcnt[k] = mcnt[k] - 1;
          if (mcnt[k] == 0) begin
            tb_done[k] = 1'b1;
            mbusy[k]   = 1'b0;
            n_done[k]  = n_done[k] + 1;
          end
        end
      end
    end
  end

  initial begin
    int g;
    int t;
    int base;
    reset = 1'b1;
    count = 14'd0;
    trig[0] = 1'b0;
    trig[1] = 1'b0;
    hold = 1'b0;
    cyc = 0;
    chk_first = 1'b0;
    exp_first = 0;
    n_checks = 0;
    n_fail = 0;
    for (int k = 0; k < 2; k++) begin
      n_start[k] = 0;
      n_done[k]  = 0;
    end
    repeat (3) tick();
    for (int k = 0; k < 2; k++) begin
      check("reset_tx_start", {31'd0, ts[k]}, 32'd0);
      check("reset_tx_data", {24'd0, td[k]}, 32'd0);
      check("reset_busy", {31'd0, bz[k]}, 32'd0);
    end
    reset = 1'b0;
    tick();

    // 4-byte frame without CR LF
    count = 14'd7;
    q0.push_back(8'h30); q0.push_back(8'h30); q0.push_back(8'h30); q0.push_back(8'h37);
    pulse(0);
    wait_idle(0);
    check("nocrlf_start_count", n_start[0], 32'd4);

    // 1234 with CR LF, a dropped trigger during byte 2, a dropped trigger at the final done
    count = 14'd1234;
    q1.push_back(8'h31); q1.push_back(8'h32); q1.push_back(8'h33);
    q1.push_back(8'h34); q1.push_back(8'h0D); q1.push_back(8'h0A);
    exp_first = cyc + 15;
    chk_first = 1'b1;
    pulse(1);
    check("busy_rise", {31'd0, bz[1]}, 32'd1);
    count = 14'd555;
    g = 0;
    while (n_start[1] < 2 && g < 500) begin tick(); g++; end
    if (g >= 500) timeout("byte2_start");
    pulse(1);
    g = 0;
    while (!(tb_done[1] && n_done[1] == 6) && g < 500) begin tick(); g++; end
    if (g >= 500) timeout("final_done");
    check("busy_before_final_done", {31'd0, bz[1]}, 32'd1);
    check("first_start_seen", {31'd0, chk_first}, 32'd0);
    trig[1] = 1'b1;
    tick();
    check("busy_fall", {31'd0, bz[1]}, 32'd0);
    check("frame1_starts", n_start[1], 32'd6);
    check("frame1_drained", q1.size(), 32'd0);

    // Trigger held into D+1 starts a new frame; 12000 saturates to 9999
    count = 14'd12000;
    q1.push_back(8'h39); q1.push_back(8'h39); q1.push_back(8'h39);
    q1.push_back(8'h39); q1.push_back(8'h0D); q1.push_back(8'h0A);
    exp_first = cyc + 15;
    chk_first = 1'b1;
    tick();
    trig[1] = 1'b0;
    check("busy_new_frame", {31'd0, bz[1]}, 32'd1);
    wait_idle(1);
    check("frame2_starts", n_start[1], 32'd12);

    // tx_busy held high when the first byte becomes eligible
    count = 14'd1000;
    q1.push_back(8'h31); q1.push_back(8'h30); q1.push_back(8'h30);
    q1.push_back(8'h30); q1.push_back(8'h0D); q1.push_back(8'h0A);
    t = cyc + 1;
    pulse(1);
    while (cyc < t + 13) tick();
    hold = 1'b1;
    base = n_start[1];
    repeat (20) tick();
    check("hold_no_start", n_start[1], base);
    hold = 1'b0;
    exp_first = cyc + 1;
    chk_first = 1'b1;
    wait_idle(1);
    check("hold_start_seen", {31'd0, chk_first}, 32'd0);
    check("frame3_starts", n_start[1], base + 6);

    // Reset during WAIT_DONE of the third byte aborts the frame
    count = 14'd4321;
    q1.push_back(8'h34); q1.push_back(8'h33); q1.push_back(8'h32);
    base = n_start[1];
    pulse(1);
    g = 0;
    while (n_start[1] < base + 3 && g < 500) begin tick(); g++; end
    if (g >= 500) timeout("byte3_start");
    repeat (3) tick();
    reset = 1'b1;
    #1;
    check("abort_tx_start", {31'd0, ts[1]}, 32'd0);
    check("abort_tx_data", {24'd0, td[1]}, 32'd0);
    check("abort_busy", {31'd0, bz[1]}, 32'd0);
    repeat (2) tick();
    reset = 1'b0;
    base = n_start[1];
    repeat (40) tick();
    check("no_stray_start", n_start[1], base);
    check("abort_drained", q1.size(), 32'd0);

    // Fresh frame after the abort; zero keeps its leading zeros
    count = 14'd0;
    q1.push_back(8'h30); q1.push_back(8'h30); q1.push_back(8'h30);
    q1.push_back(8'h30); q1.push_back(8'h0D); q1.push_back(8'h0A);
    pulse(1);
    wait_idle(1);
    check("frame4_starts", n_start[1], base + 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
